op_handler_dispatcher: RTL and testbench

// - Initiator side of the OpHandler_IF protocol. The opcode handlers are the responders.
// - Accepts one decoded Op_st at a time from the upstream op source (valid/rdy).
// - Holds the op stable on op_out, which feeds the input chooser's op select.
// - Waits for the selected handler to be ready, pulses trigger, then waits for done.
// - A watchdog flags a handler that never becomes ready or never completes.

---
 rtl/op_handler_dispatcher_pkg.sv | 20 ++
 rtl/op_handler_dispatcher_watchdog_timer.sv | 41 ++++
 rtl/op_handler_dispatcher.sv | 107 ++++++++++
 tb/tb_op_handler_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_handler_dispatcher_pkg.sv
// Shared types for the op handler dispatcher: the decoded op, the dispatcher FSM states
// and the default watchdog limit.
package op_handler_dispatcher_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
  } Op_st;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    TRIGGER   = 3'd2,
    WAIT_DONE = 3'd3,
    ERROR     = 3'd4
  } DispState_e;

  localparam int unsigned DISP_TIMEOUT_DEFAULT = 32'd1 << 20;

endpackage

// File: rtl/op_handler_dispatcher_watchdog_timer.sv
// Cycle counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
// A TIMEOUT_CYCLES of 0 removes the counter and never expires.
module op_handler_dispatcher_watchdog_timer
  import op_handler_dispatcher_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DISP_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset_n, clear, enable};
      assign expired       = 1'b0;
    end else begin : g_enabled
      localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
      logic [WD_W-1:0] count_reg;

      // Expiry is raised while counting the last allowed cycle, so the FSM leaves on that edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && !expired) begin
          count_reg <= count_reg + WD_W'(1);
        end
      end

      assign expired = enable && (count_reg == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/op_handler_dispatcher.sv
// Initiator side of the handler trigger/rdy/done handshake: latches one op, waits for the
// selected handler, pulses trigger once and waits for done, with a watchdog to ERROR.
module op_handler_dispatcher
  import op_handler_dispatcher_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DISP_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  Op_st             op_in,
  input  logic             op_valid,
  output logic             op_rdy,
  output Op_st             op_out,
  output logic             handler_trigger,
  input  logic             handler_rdy,
  input  logic             handler_done,
  input  logic             clear_err,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] ops_done_count
);

  DispState_e state_reg;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  assign wd_clear  = (state_reg == IDLE) && op_valid && op_rdy;
  assign wd_enable = (state_reg == WAIT_RDY) || (state_reg == TRIGGER) ||
                     (state_reg == WAIT_DONE);

  op_handler_dispatcher_watchdog_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // op_rdy stays low in the cycle right after reset and rises on the first IDLE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      op_out          <= '0;
      op_rdy          <= 1'b0;
      handler_trigger <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      ops_done_count  <= '0;
    end else begin
      handler_trigger <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (op_valid && op_rdy) begin
            op_out    <= op_in;
            state_reg <= WAIT_RDY;
            op_rdy    <= 1'b0;
            busy      <= 1'b1;
          end else begin
            op_rdy <= 1'b1;
            busy   <= 1'b0;
          end
        end
        WAIT_RDY: begin
          if (wd_expired) begin
            state_reg   <= ERROR;
            timeout_err <= 1'b1;
          end else if (handler_rdy) begin
            state_reg       <= TRIGGER;
            handler_trigger <= 1'b1;
          end
        end
        TRIGGER, WAIT_DONE: begin
          // Completion wins over a watchdog expiry in the same cycle.
          if (handler_done) begin
            state_reg      <= IDLE;
            op_rdy         <= 1'b1;
            busy           <= 1'b0;
            ops_done_count <= ops_done_count + CNT_W'(1);
          end else if (wd_expired) begin
            state_reg   <= ERROR;
            timeout_err <= 1'b1;
          end else begin
            state_reg <= WAIT_DONE;
          end
        end
        ERROR: begin
          if (clear_err) begin
            state_reg   <= IDLE;
            op_rdy      <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          op_rdy    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_handler_dispatcher.sv
// Directed bench for op_handler_dispatcher: a long-timeout instance for the handshake
// scenarios and an 8-cycle-timeout instance for the watchdog scenario.
module tb_op_handler_dispatcher;
  import op_handler_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  Op_st        op_in, op_out;
  logic        op_valid, op_rdy, handler_trigger, handler_rdy, handler_done;
  logic        clear_err, busy, timeout_err;
  logic [15:0] ops_done_count;

  Op_st        t_op_in, t_op_out;
  logic        t_op_valid, t_op_rdy, t_handler_trigger, t_handler_rdy, t_handler_done;
  logic        t_clear_err, t_busy, t_timeout_err;
  logic [15:0] t_ops_done_count;

  logic [3:0]  flags, t_flags;
  int          errors = 0;
  int          checks = 0;

  assign flags   = {op_rdy, busy, handler_trigger, timeout_err};
  assign t_flags = {t_op_rdy, t_busy, t_handler_trigger, t_timeout_err};

  always #5 clk = ~clk;

  op_handler_dispatcher #(.TIMEOUT_CYCLES(1000), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .op_in(op_in), .op_valid(op_valid), .op_rdy(op_rdy),
    .op_out(op_out), .handler_trigger(handler_trigger), .handler_rdy(handler_rdy),
    .handler_done(handler_done), .clear_err(clear_err), .busy(busy),
    .timeout_err(timeout_err), .ops_done_count(ops_done_count)
  );

  op_handler_dispatcher #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .op_in(t_op_in), .op_valid(t_op_valid), .op_rdy(t_op_rdy),
    .op_out(t_op_out), .handler_trigger(t_handler_trigger), .handler_rdy(t_handler_rdy),
    .handler_done(t_handler_done), .clear_err(t_clear_err), .busy(t_busy),
    .timeout_err(t_timeout_err), .ops_done_count(t_ops_done_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    op_in = '0; op_valid = 1'b0; handler_rdy = 1'b0; handler_done = 1'b0; clear_err = 1'b0;
    t_op_in = '0; t_op_valid = 1'b0; t_handler_rdy = 1'b0; t_handler_done = 1'b0;
    t_clear_err = 1'b0;
    #2 reset_n = 1'b0;
    tick; tick;
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++;
    if (op_out !== 24'h0 || ops_done_count !== 16'd0) begin
      errors++; $display("FAIL reset_data: got op_out=%h count=%0d want 0/0", op_out, ops_done_count);
    end
    reset_n = 1'b1;
    tick;
    checks++;
    if (flags !== 4'b1000) begin errors++; $display("FAIL idle_flags: got %b want 1000", flags); end
    checks++;
    if (t_flags !== 4'b1000) begin errors++; $display("FAIL idle_flags_t: got %b want 1000", t_flags); end
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    tick;
    checks++;
    if (ops_done_count !== 16'd0 || flags !== 4'b1000) begin
      errors++; $display("FAIL idle_done_ignored: got count=%0d flags=%b want 0/1000", ops_done_count, flags);
    end
    $display("reset: idle after release");
  endtask

  task automatic test_g01;
    Op_st op_a;
    op_a = '{opcode: 8'h01, operand: 16'hA5A5};
    handler_rdy = 1'b1; op_in = op_a; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    checks++;
    if (flags !== 4'b0100 || op_out !== op_a) begin
      errors++; $display("FAIL g01_accept: got flags=%b op_out=%h want 0100/%h", flags, op_out, op_a);
    end
    tick;
    checks++;
    if (flags !== 4'b0110) begin errors++; $display("FAIL g01_trigger: got %b want 0110", flags); end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (flags !== 4'b0100 || ops_done_count !== 16'd0) begin
        errors++; $display("FAIL g01_wait_done: cycle %0d got flags=%b count=%0d want 0100/0", i, flags, ops_done_count);
      end
    end
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    checks++;
    if (flags !== 4'b1000 || ops_done_count !== 16'd1) begin
      errors++; $display("FAIL g01_done: got flags=%b count=%0d want 1000/1", flags, ops_done_count);
    end
    $display("op G01 dispatched, count=%0d", ops_done_count);
  endtask

  task automatic test_g02;
    Op_st op_b;
    op_b = '{opcode: 8'h02, operand: 16'h1234};
    handler_rdy = 1'b0; op_in = op_b; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    op_in = '{opcode: 8'hEE, operand: 16'hFFFF};
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (flags !== 4'b0100 || op_out !== op_b) begin
        errors++; $display("FAIL g02_hold: cycle %0d got flags=%b op_out=%h want 0100/%h", i, flags, op_out, op_b);
      end
    end
    handler_rdy = 1'b1;
    tick;
    checks++;
    if (flags !== 4'b0110) begin errors++; $display("FAIL g02_trigger: got %b want 0110", flags); end
    tick;
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL g02_single_trigger: got %b want 0100", flags); end
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    checks++;
    if (flags !== 4'b1000 || ops_done_count !== 16'd2 || op_out !== op_b) begin
      errors++; $display("FAIL g02_done: got flags=%b count=%0d op_out=%h want 1000/2/%h", flags, ops_done_count, op_out, op_b);
    end
    $display("op G02 dispatched, count=%0d", ops_done_count);
  endtask

  task automatic test_m05;
    Op_st op_c;
    op_c = '{opcode: 8'h05, operand: 16'h0005};
    handler_rdy = 1'b1; op_in = op_c; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    tick;
    checks++;
    if (flags !== 4'b0110) begin errors++; $display("FAIL m05_trigger: got %b want 0110", flags); end
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    checks++;
    if (flags !== 4'b1000 || ops_done_count !== 16'd3) begin
      errors++; $display("FAIL m05_zero_latency: got flags=%b count=%0d want 1000/3", flags, ops_done_count);
    end
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    tick;
    checks++;
    if (ops_done_count !== 16'd3) begin
      errors++; $display("FAIL m05_late_done: got count=%0d want 3", ops_done_count);
    end
    $display("op M05 dispatched, count=%0d", ops_done_count);
  endtask

  task automatic test_back_to_back;
    Op_st ops [3];
    int   trigs, accepts, consec, guard;
    logic prev_trig;
    ops[0] = '{opcode: 8'h10, operand: 16'h0001};
    ops[1] = '{opcode: 8'h11, operand: 16'h0002};
    ops[2] = '{opcode: 8'h12, operand: 16'h0003};
    trigs = 0; accepts = 0; consec = 0; guard = 0; prev_trig = 1'b0;
    handler_rdy = 1'b1; handler_done = 1'b0; op_in = ops[0]; op_valid = 1'b1;
    while (!(trigs == 3 && op_rdy) && guard < 60) begin
      if (op_valid && op_rdy) accepts++;
      tick;
      guard++;
      handler_done = 1'b0;
      if (accepts >= 3) op_valid = 1'b0;
      else op_in = ops[accepts];
      if (handler_trigger) begin
        if (prev_trig) consec++;
        trigs++;
        handler_done = 1'b1;
        $display("back-to-back trigger %0d, op_out=%h", trigs, op_out);
      end
      prev_trig = handler_trigger;
    end
    checks++;
    if (guard >= 60) begin errors++; $display("FAIL b2b_timeout: got %0d cycles want <60", guard); end
    checks++;
    if (trigs != 3 || accepts != 3 || consec != 0) begin
      errors++; $display("FAIL b2b_triggers: got trigs=%0d accepts=%0d consec=%0d want 3/3/0", trigs, accepts, consec);
    end
    checks++;
    if (ops_done_count !== 16'd6 || op_out !== ops[2]) begin
      errors++; $display("FAIL b2b_count: got count=%0d op_out=%h want 6/%h", ops_done_count, op_out, ops[2]);
    end
  endtask

  task automatic test_timeout;
    Op_st op_d, op_e;
    op_d = '{opcode: 8'h0D, operand: 16'hDEAD};
    op_e = '{opcode: 8'h0E, operand: 16'hBEEF};
    t_handler_rdy = 1'b1; t_op_in = op_d; t_op_valid = 1'b1;
    tick;
    t_op_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (t_timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: cycle %0d got 1 want 0", i); end
      tick;
    end
    checks++;
    if (t_flags !== 4'b0101 || t_op_out !== op_d) begin
      errors++; $display("FAIL to_error: got flags=%b op_out=%h want 0101/%h", t_flags, t_op_out, op_d);
    end
    tick;
    checks++;
    if (t_flags !== 4'b0101) begin errors++; $display("FAIL to_sticky: got %b want 0101", t_flags); end
    t_clear_err = 1'b1;
    tick;
    t_clear_err = 1'b0;
    checks++;
    if (t_flags !== 4'b1000 || t_ops_done_count !== 16'd0) begin
      errors++; $display("FAIL to_clear: got flags=%b count=%0d want 1000/0", t_flags, t_ops_done_count);
    end
    t_op_in = op_e; t_op_valid = 1'b1;
    tick;
    t_op_valid = 1'b0;
    checks++;
    if (t_flags !== 4'b0100 || t_op_out !== op_e) begin
      errors++; $display("FAIL to_next_accept: got flags=%b op_out=%h want 0100/%h", t_flags, t_op_out, op_e);
    end
    $display("timeout op dropped, next op accepted");
  endtask

  task automatic test_reset_mid;
    Op_st op_f;
    op_f = '{opcode: 8'h0F, operand: 16'h5555};
    handler_rdy = 1'b1; op_in = op_f; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    tick;
    tick;
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL rm_wait_done: got %b want 0100", flags); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (flags !== 4'b0000 || op_out !== 24'h0 || ops_done_count !== 16'd0) begin
      errors++; $display("FAIL rm_async: got flags=%b op_out=%h count=%0d want 0000/0/0", flags, op_out, ops_done_count);
    end
    tick;
    reset_n = 1'b1;
    tick;
    handler_done = 1'b1;
    tick;
    handler_done = 1'b0;
    checks++;
    if (flags !== 4'b1000 || ops_done_count !== 16'd0) begin
      errors++; $display("FAIL rm_done_ignored: got flags=%b count=%0d want 1000/0", flags, ops_done_count);
    end
    $display("reset mid-op: outputs cleared");
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation stall want completion");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    test_reset;
    test_g01;
    test_g02;
    test_m05;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
